// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter and instruction fetch from synchronous-read program RAM
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    INSTR_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   PCEn,
  input  logic                   BranchEn,
  input  logic [7:0]             BranchDisp,
  input  logic                   JumpEn,
  input  logic [ADDR_WIDTH-1:0]  JumpTarget,
  input  logic [INSTR_WIDTH-1:0] MemData,
  output logic [ADDR_WIDTH-1:0]  MemAddr,
  output logic [ADDR_WIDTH-1:0]  PC,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic                   InstrValid,
  output logic [ADDR_WIDTH-1:0]  LinkAddr
);

  // FETCH: address on bus; WAIT: RAM data arrives; HOLD: instruction presented until retired
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;

  logic [ADDR_WIDTH-1:0]  seq_pc;
  logic [ADDR_WIDTH-1:0]  disp_ext;
  logic [ADDR_WIDTH-1:0]  next_pc;

  // Next-PC selection: jump beats branch beats sequential; all sums wrap naturally
  always_comb begin
    seq_pc   = pc_q + ONE;
    disp_ext = {{(ADDR_WIDTH-8){BranchDisp[7]}}, BranchDisp};
    next_pc  = seq_pc;
    if (JumpEn) begin
      next_pc = JumpTarget;
    end else if (BranchEn) begin
      next_pc = seq_pc + disp_ext;
    end
  end

  // Fetch sequencing; PCEn only matters once an instruction is being held
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      S_FETCH: begin
        valid_d = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        instr_d = MemData;
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (PCEn) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers; reset abandons any read in flight since FETCH never latches data
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign MemAddr    = pc_q;
  assign PC         = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign LinkAddr   = pc_q + ONE;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit with a PC reference model
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcen;
  logic        branch_en;
  logic [7:0]  branch_disp;
  logic        jump_en;
  logic [15:0] jump_target;
  logic [15:0] mem_data = 16'h0000;
  logic [15:0] mem_addr;
  logic [15:0] pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] link_addr;

  logic [15:0] ram [0:65535];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pc   = 0;

  instr_fetch_unit #(
    .ADDR_WIDTH (16),
    .RESET_PC   (16'h0000),
    .INSTR_WIDTH(16)
  ) dut (
    .Clk       (clk),
    .Reset     (reset),
    .PCEn      (pcen),
    .BranchEn  (branch_en),
    .BranchDisp(branch_disp),
    .JumpEn    (jump_en),
    .JumpTarget(jump_target),
    .MemData   (mem_data),
    .MemAddr   (mem_addr),
    .PC        (pc),
    .Instr     (instr),
    .InstrValid(instr_valid),
    .LinkAddr  (link_addr)
  );

  always #5 clk = ~clk;

  // Synchronous-read program RAM, one cycle latency
  always @(posedge clk) mem_data <= ram[mem_addr];

  // Architectural next-PC rule expressed as integer arithmetic modulo 2^16
  function automatic int model_next(int cur, bit j, bit b, logic [7:0] d, logic [15:0] t);
    int disp;
    disp = int'($signed(d));
    if (j) return int'(t);
    if (b) return (((cur + 1 + disp) % 65536) + 65536) % 65536;
    return (cur + 1) % 65536;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl;
    pcen        = 1'b0;
    branch_en   = 1'b0;
    jump_en     = 1'b0;
    branch_disp = 8'h00;
    jump_target = 16'h0000;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (instr_valid !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    n_checks++;
    if (instr_valid !== 1'b1) begin
      $display("FAIL %s_timeout InstrValid got %b want 1", tag, instr_valid);
      n_fail++;
    end
  endtask

  // Retire the held instruction for one cycle and check the new PC against the model
  task automatic retire(input bit j, input bit b, input logic [7:0] d, input logic [15:0] t);
    pcen        = 1'b1;
    jump_en     = j;
    branch_en   = b;
    branch_disp = d;
    jump_target = t;
    exp_pc      = model_next(exp_pc, j, b, d, t);
    tick();
    clear_ctrl();
    n_checks++;
    if (pc !== exp_pc[15:0]) begin
      $display("FAIL retire_pc got %h want %h", pc, exp_pc[15:0]);
      n_fail++;
    end
    n_checks++;
    if (instr_valid !== 1'b0) begin
      $display("FAIL retire_valid got %b want 0", instr_valid);
      n_fail++;
    end
  endtask

  task automatic goto_pc(input logic [15:0] a);
    wait_valid("goto_pre");
    retire(1'b1, 1'b0, 8'h00, a);
    wait_valid("goto_post");
  endtask

  task automatic test_reset;
    ram[0] = 16'h1234;
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (pc !== 16'h0000) begin $display("FAIL reset_pc got %h want 0000", pc); n_fail++; end
    n_checks++; if (mem_addr !== 16'h0000) begin $display("FAIL reset_memaddr got %h want 0000", mem_addr); n_fail++; end
    n_checks++; if (instr_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", instr_valid); n_fail++; end
    n_checks++; if (instr !== 16'h0000) begin $display("FAIL reset_instr got %h want 0000", instr); n_fail++; end
    reset = 1'b0;
    exp_pc = 0;
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin $display("FAIL first_fetch_valid got %b want 0", instr_valid); n_fail++; end
    tick();
    n_checks++; if (instr_valid !== 1'b1) begin $display("FAIL first_wait_valid got %b want 1", instr_valid); n_fail++; end
    n_checks++; if (instr !== 16'h1234) begin $display("FAIL first_instr got %h want 1234", instr); n_fail++; end
    n_checks++; if (pc !== 16'h0000) begin $display("FAIL first_pc got %h want 0000", pc); n_fail++; end
  endtask

  task automatic test_sequential;
    goto_pc(16'h0005);
    n_checks++; if (instr !== ram[5]) begin $display("FAIL seq_instr5 got %h want %h", instr, ram[5]); n_fail++; end
    ram[6] = 16'hABCD;
    retire(1'b0, 1'b0, 8'h00, 16'h0000);
    n_checks++; if (pc !== 16'h0006) begin $display("FAIL seq_pc got %h want 0006", pc); n_fail++; end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin $display("FAIL seq_valid_c2 got %b want 0", instr_valid); n_fail++; end
    tick();
    n_checks++; if (instr_valid !== 1'b1) begin $display("FAIL seq_valid_c3 got %b want 1", instr_valid); n_fail++; end
    n_checks++; if (instr !== 16'hABCD) begin $display("FAIL seq_instr got %h want abcd", instr); n_fail++; end
  endtask

  task automatic test_branch;
    goto_pc(16'h0010);
    retire(1'b0, 1'b1, 8'hFC, 16'h0000);
    n_checks++; if (pc !== 16'h000D) begin $display("FAIL branch_neg got %h want 000d", pc); n_fail++; end
    goto_pc(16'h0010);
    retire(1'b0, 1'b1, 8'h05, 16'h0000);
    n_checks++; if (pc !== 16'h0016) begin $display("FAIL branch_pos got %h want 0016", pc); n_fail++; end
  endtask

  task automatic test_jump_wrap;
    wait_valid("jump_pre");
    retire(1'b1, 1'b1, 8'h7F, 16'h0200);
    n_checks++; if (pc !== 16'h0200) begin $display("FAIL jump_priority got %h want 0200", pc); n_fail++; end
    goto_pc(16'hFFFF);
    n_checks++; if (link_addr !== 16'h0000) begin $display("FAIL link_wrap got %h want 0000", link_addr); n_fail++; end
    retire(1'b0, 1'b0, 8'h00, 16'h0000);
    n_checks++; if (pc !== 16'h0000) begin $display("FAIL seq_wrap got %h want 0000", pc); n_fail++; end
    wait_valid("wrap1");
    retire(1'b0, 1'b1, 8'hFF, 16'h0000);
    n_checks++; if (pc !== 16'h0000) begin $display("FAIL branch_m1 got %h want 0000", pc); n_fail++; end
    wait_valid("wrap2");
    retire(1'b0, 1'b1, 8'hFE, 16'h0000);
    n_checks++; if (pc !== 16'hFFFF) begin $display("FAIL branch_m2 got %h want ffff", pc); n_fail++; end
  endtask

  task automatic test_ignored_pcen;
    goto_pc(16'h0003);
    pcen = 1'b1;
    tick();
    exp_pc = 4;
    n_checks++; if (pc !== 16'h0004) begin $display("FAIL ign_adv got %h want 0004", pc); n_fail++; end
    tick();
    n_checks++; if (pc !== 16'h0004) begin $display("FAIL ign_fetch got %h want 0004", pc); n_fail++; end
    tick();
    n_checks++; if (pc !== 16'h0004) begin $display("FAIL ign_wait got %h want 0004", pc); n_fail++; end
    n_checks++; if (instr_valid !== 1'b1) begin $display("FAIL ign_valid got %b want 1", instr_valid); n_fail++; end
    clear_ctrl();
    jump_en     = 1'b1;
    branch_en   = 1'b1;
    branch_disp = 8'h40;
    jump_target = 16'h0999;
    tick();
    clear_ctrl();
    n_checks++; if (pc !== 16'h0004 || instr_valid !== 1'b1) begin
      $display("FAIL no_pcen_hold got pc %h valid %b want 0004 1", pc, instr_valid); n_fail++; end
    retire(1'b0, 1'b0, 8'h00, 16'h0000);
    n_checks++; if (pc !== 16'h0005) begin $display("FAIL ign_second_adv got %h want 0005", pc); n_fail++; end
  endtask

  task automatic test_reset_mid;
    ram[16'h0040] = 16'hDEAD;
    ram[0]        = 16'h5A5A;
    wait_valid("rst_mid_pre");
    pcen        = 1'b1;
    jump_en     = 1'b1;
    jump_target = 16'h0040;
    tick();
    clear_ctrl();
    tick();
    n_checks++; if (pc !== 16'h0040 || instr_valid !== 1'b0) begin
      $display("FAIL rst_mid_setup got pc %h valid %b want 0040 0", pc, instr_valid); n_fail++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_pc = 0;
    n_checks++; if (pc !== 16'h0000) begin $display("FAIL rst_mid_pc got %h want 0000", pc); n_fail++; end
    n_checks++; if (instr_valid !== 1'b0) begin $display("FAIL rst_mid_valid got %b want 0", instr_valid); n_fail++; end
    n_checks++; if (instr !== 16'h0000) begin $display("FAIL rst_mid_instr got %h want 0000", instr); n_fail++; end
    tick();
    n_checks++; if (instr !== 16'h0000 || instr_valid !== 1'b0) begin
      $display("FAIL rst_mid_stale got instr %h valid %b want 0000 0", instr, instr_valid); n_fail++; end
    tick();
    n_checks++; if (instr !== 16'h5A5A || instr_valid !== 1'b1) begin
      $display("FAIL rst_mid_refetch got instr %h valid %b want 5a5a 1", instr, instr_valid); n_fail++; end
  endtask

  task automatic test_random;
    bit          j, b;
    logic [7:0]  d;
    logic [15:0] t;
    int          hold;
    for (int it = 0; it < 60; it++) begin
      wait_valid("rand");
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        branch_en   = 1'($urandom);
        jump_en     = 1'($urandom);
        jump_target = 16'($urandom);
        tick();
        clear_ctrl();
      end
      n_checks++; if (pc !== exp_pc[15:0] || instr !== ram[exp_pc]) begin
        $display("FAIL rand_hold it %0d got pc %h instr %h want %h %h", it, pc, instr, exp_pc[15:0], ram[exp_pc]); n_fail++; end
      j = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 1) == 0);
      d = 8'($urandom);
      t = 16'($urandom);
      retire(j, b, d, t);
      pcen = 1'($urandom);
      jump_en = 1'($urandom);
      jump_target = 16'($urandom);
      tick();
      clear_ctrl();
      n_checks++; if (pc !== exp_pc[15:0] || instr_valid !== 1'b0) begin
        $display("FAIL rand_fetch it %0d got pc %h valid %b want %h 0", it, pc, instr_valid, exp_pc[15:0]); n_fail++; end
      pcen = 1'($urandom);
      branch_en = 1'($urandom);
      branch_disp = 8'($urandom);
      tick();
      clear_ctrl();
      n_checks++; if (pc !== exp_pc[15:0] || instr_valid !== 1'b1 || instr !== ram[exp_pc]) begin
        $display("FAIL rand_wait it %0d got pc %h valid %b instr %h want %h 1 %h",
                 it, pc, instr_valid, instr, exp_pc[15:0], ram[exp_pc]); n_fail++; end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 16'($urandom);
    reset = 1'b1;
    clear_ctrl();
    #1;
    test_reset();
    test_sequential();
    test_branch();
    test_jump_wrap();
    test_ignored_pcen();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream neighbour of the CPU control FSM. Holds the 16-bit program counter and reads instruction words from synchronous-read program RAM. It presents a stable Instr/InstrValid pair to the control FSM, then computes the next PC when the FSM pulses PCEn. Next-PC sources are sequential, PC-relative branch, or register jump.

Parameters:
ADDR_WIDTH, 16, width of PC and memory address; arithmetic wraps modulo 2^ADDR_WIDTH
RESET_PC, 16'h0000, PC value loaded on Reset
INSTR_WIDTH, 16, instruction word width

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
PCEn  input  1  from control FSM; one-cycle pulse to retire current instruction and advance PC
BranchEn  input  1  from control FSM; qualifies PCEn, take PC-relative branch
BranchDisp  input  8  signed two's-complement displacement, in words
JumpEn  input  1  from control FSM; qualifies PCEn, take absolute jump
JumpTarget  input  ADDR_WIDTH  absolute target from register file (Rsrc)
MemData  input  INSTR_WIDTH  program RAM read data, valid one cycle after MemAddr
MemAddr  output  ADDR_WIDTH  program RAM read address
PC  output  ADDR_WIDTH  address of the instruction currently in Instr
Instr  output  INSTR_WIDTH  registered instruction word to control FSM
InstrValid  output  1  high while Instr holds a fetched, unretired instruction
LinkAddr  output  ADDR_WIDTH  PC+1 (mod 2^ADDR_WIDTH), combinational, for JAL writeback

Behaviour:
- Clocking: single clock Clk. Reset is synchronous, active-high.
- State machine: FETCH, WAIT, HOLD.
- Reset, sampled at a rising edge, overrides every other input in that cycle:
  - PC <= RESET_PC; Instr <= 0; InstrValid <= 0; state <= FETCH.
- Reset mid-operation, in any state, discards any in-flight read. The read data returned in the following cycle is ignored.
- MemAddr = PC at all times (combinational). RAM read latency is exactly 1 cycle.
- FETCH: InstrValid = 0. Address is on the bus. Next state is WAIT.
- WAIT: Instr <= MemData; InstrValid <= 1; next state is HOLD.
- Latency: 2 cycles from PC update to InstrValid = 1.
- HOLD: Instr, PC and InstrValid are held stable until PCEn = 1. On PCEn:
  - Next PC priority: JumpEn > BranchEn > sequential.
  - JumpEn = 1: PC <= JumpTarget.
  - else BranchEn = 1: PC <= PC + 1 + sign_extend(BranchDisp), truncated to ADDR_WIDTH.
  - else: PC <= PC + 1.
  - InstrValid <= 0; state <= FETCH.
- PCEn in FETCH or WAIT is ignored. PC is not modified, and no error is flagged.
- BranchEn or JumpEn without PCEn: no effect.
- Wrap-around: all PC arithmetic is modulo 2^ADDR_WIDTH.
  - Sequential from 16'hFFFF -> 16'h0000.
  - Branch from 16'h0000 with disp -1 -> 16'h0000.
  - Branch from 16'h0000 with disp -2 -> 16'hFFFF.
- Simultaneous JumpEn and BranchEn with PCEn: jump wins, branch is ignored.
- Throughput: at most one instruction per 3 cycles (FETCH, WAIT, HOLD of at least 1 cycle).
- Instr changes only in WAIT. Instr is never 'X' after reset.

Test Plan:
- Reset then run: Reset=1 for 2 cycles, RAM[0]=16'h1234. -> MemAddr=0; InstrValid=1 with Instr=16'h1234 on the 2nd edge after Reset falls; PC=0.
- Sequential advance: PCEn pulse in HOLD with PC=5, RAM[6]=16'hABCD. -> PC=6 next edge, InstrValid=0 for 2 cycles, then Instr=16'hABCD.
- Branch, both signs: PC=16'h0010, BranchDisp=8'hFC, BranchEn=PCEn=1 -> PC=16'h000D. PC=16'h0010, BranchDisp=8'h05 -> PC=16'h0016.
- Jump priority and wrap:
  - JumpEn=BranchEn=PCEn=1, JumpTarget=16'h0200 -> PC=16'h0200.
  - Sequential from PC=16'hFFFF -> PC=16'h0000; LinkAddr=16'h0000 while PC=16'hFFFF.
- Ignored PCEn: PCEn held 1 through FETCH and WAIT after the first advance from PC=3. -> PC=4 only; advances again only in HOLD.
- Reset mid-fetch: Reset asserted during WAIT at PC=16'h0040. -> next edge PC=RESET_PC, InstrValid=0, Instr=0; the stale MemData from 16'h0040 is never latched.
